// File: rtl/bb_pkg.sv
// Shared constants, FSM encoding and slot helpers for the baseband load controller.
package bb_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam logic [3:0] TYPE_CA    = 4'h1;
    localparam logic [3:0] TYPE_MSG   = 4'h2;
    localparam logic [3:0] TYPE_DELAY = 4'h3;
    localparam int         CA_WORDS   = 32;
    localparam int         MSG_WORDS  = 47;
    localparam logic [9:0] MAX_DELAY  = 10'd1022;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_PAYLOAD,
        ST_CHECK
    } state_t;

    // Slot numbering shared by wren and slot_loaded: {is_msg, ch}
    function automatic logic [3:0] slot_of(input logic is_msg, input logic [2:0] ch);
        return {is_msg, ch};
    endfunction

    function automatic logic [15:0] slot_mask(input logic [3:0] slot);
        return 16'(1) << slot;
    endfunction

endpackage

// File: rtl/bb_load_ctrl_if.sv
// Word stream from the USB3 receive FIFO into the load controller.
interface bb_load_ctrl_if;

    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/bb_delay_bank.sv
// Per-channel code delay registers fed from a single shadow register.
module bb_delay_bank (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_shadow_we,
    input  logic [9:0]      i_shadow_d,
    input  logic            i_load,
    input  logic [2:0]      i_ch,
    output logic [9:0]      o_shadow,
    output logic [7:0][9:0] o_delay_ca
);

    logic [9:0]      r_shadow;
    logic [7:0][9:0] r_delay;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
            r_delay  <= '0;
        end else begin
            if (i_shadow_we)
                r_shadow <= i_shadow_d;
            if (i_load)
                r_delay[i_ch] <= r_shadow;
        end
    end

    assign o_shadow   = r_shadow;
    assign o_delay_ca = r_delay;

endmodule

// File: rtl/bb_load_ctrl.sv
// Parses FIFO words into C/A, message and code-delay load frames and drives
// the baseband RAM write port, delay registers and load status.
module bb_load_ctrl
    import bb_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    bb_load_ctrl_if.slave   s_in,
    output logic [31:0]     o_wr_data,
    output logic [5:0]      o_wr_addr,
    output logic [15:0]     o_wren,
    output logic [7:0][9:0] o_delay_ca,
    output logic [15:0]     o_slot_loaded,
    output logic            o_frame_ok,
    output logic            o_frame_err,
    output logic [7:0]      o_err_cnt
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_type;
    logic [2:0]  r_ch;
    logic [5:0]  r_idx;
    logic [31:0] r_acc;

    logic [31:0] r_wr_data;
    logic [5:0]  r_wr_addr;
    logic [15:0] r_wren;
    logic [15:0] r_slot;
    logic        r_ok;
    logic        r_err;
    logic [7:0]  r_err_cnt;

    logic        w_take;
    logic        w_sync;
    logic [3:0]  w_hdr_type;
    logic        w_type_ok;
    logic        w_is_delay;
    logic        w_is_msg;
    logic [5:0]  w_last_idx;
    logic        w_hdr_take;
    logic        w_pay_take;
    logic        w_chk_take;
    logic        w_bad_type;
    logic        w_good;
    logic        w_bad;
    logic [9:0]  w_shadow;
    logic [3:0]  w_hdr_slot;
    logic [3:0]  w_cur_slot;

    assign s_in.in_ready = ~rst;
    assign w_take        = s_in.in_valid & s_in.in_ready;
    assign w_sync        = s_in.in_data[31:24] == SYNC_BYTE;
    assign w_hdr_type    = s_in.in_data[23:20];
    assign w_type_ok     = (w_hdr_type == TYPE_CA) ||
                           (w_hdr_type == TYPE_MSG) ||
                           (w_hdr_type == TYPE_DELAY);
    assign w_is_delay    = r_type == TYPE_DELAY;
    assign w_is_msg      = r_type == TYPE_MSG;
    assign w_hdr_slot    = slot_of(w_hdr_type == TYPE_MSG, s_in.in_data[18:16]);
    assign w_cur_slot    = slot_of(w_is_msg, r_ch);

    always_comb begin
        w_last_idx = 6'd0;
        case (r_type)
            TYPE_CA:  w_last_idx = 6'(CA_WORDS - 1);
            TYPE_MSG: w_last_idx = 6'(MSG_WORDS - 1);
            default:  w_last_idx = 6'd0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hdr_take  = 1'b0;
        w_pay_take  = 1'b0;
        w_chk_take  = 1'b0;
        w_bad_type  = 1'b0;
        unique case (r_state)
            ST_HUNT: begin
                if (w_take && w_sync) begin
                    if (w_type_ok) begin
                        w_hdr_take  = 1'b1;
                        w_state_nxt = ST_PAYLOAD;
                    end else begin
                        w_bad_type  = 1'b1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (w_take) begin
                    w_pay_take = 1'b1;
                    if (r_idx == w_last_idx)
                        w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (w_take) begin
                    w_chk_take  = 1'b1;
                    w_state_nxt = ST_HUNT;
                end
            end
            default: w_state_nxt = ST_HUNT;
        endcase
    end

    // An out-of-range delay fails the frame even when the checksum matches
    assign w_good = w_chk_take && (s_in.in_data == r_acc) &&
                    (!w_is_delay || (w_shadow <= MAX_DELAY));
    assign w_bad  = w_bad_type || (w_chk_take && !w_good);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_HUNT;
            r_type  <= 4'h0;
            r_ch    <= 3'd0;
            r_idx   <= 6'd0;
            r_acc   <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hdr_take) begin
                r_type <= w_hdr_type;
                r_ch   <= s_in.in_data[18:16];
                r_idx  <= 6'd0;
                r_acc  <= 32'h0;
            end else if (w_pay_take) begin
                r_idx  <= r_idx + 6'd1;
                r_acc  <= r_acc ^ s_in.in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_data <= 32'h0;
            r_wr_addr <= 6'd0;
            r_wren    <= 16'h0;
            r_slot    <= 16'h0;
            r_ok      <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            r_wren <= 16'h0;
            r_ok   <= w_good;
            r_err  <= w_bad;
            if (w_pay_take && !w_is_delay) begin
                r_wren    <= slot_mask(w_cur_slot);
                r_wr_addr <= r_idx;
                r_wr_data <= s_in.in_data;
            end
            if (w_hdr_take && (w_hdr_type != TYPE_DELAY))
                r_slot[w_hdr_slot] <= 1'b0;
            if (w_good && !w_is_delay)
                r_slot[w_cur_slot] <= 1'b1;
            if (w_bad && (r_err_cnt != 8'hFF))
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    bb_delay_bank u_delay_bank (
        .clk         (clk),
        .rst         (rst),
        .i_shadow_we (w_pay_take && w_is_delay),
        .i_shadow_d  (s_in.in_data[9:0]),
        .i_load      (w_good && w_is_delay),
        .i_ch        (r_ch),
        .o_shadow    (w_shadow),
        .o_delay_ca  (o_delay_ca)
    );

    assign o_wr_data     = r_wr_data;
    assign o_wr_addr     = r_wr_addr;
    assign o_wren        = r_wren;
    assign o_slot_loaded = r_slot;
    assign o_frame_ok    = r_ok;
    assign o_frame_err   = r_err;
    assign o_err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_bb_load_ctrl.sv
// Directed-frame bench for bb_load_ctrl with a frame-level reference model.
module tb_bb_load_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    bb_load_ctrl_if bus ();

    logic [31:0]     o_wr_data;
    logic [5:0]      o_wr_addr;
    logic [15:0]     o_wren;
    logic [7:0][9:0] o_delay_ca;
    logic [15:0]     o_slot_loaded;
    logic            o_frame_ok;
    logic            o_frame_err;
    logic [7:0]      o_err_cnt;

    bb_load_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .s_in          (bus),
        .o_wr_data     (o_wr_data),
        .o_wr_addr     (o_wr_addr),
        .o_wren        (o_wren),
        .o_delay_ca    (o_delay_ca),
        .o_slot_loaded (o_slot_loaded),
        .o_frame_ok    (o_frame_ok),
        .o_frame_err   (o_frame_err),
        .o_err_cnt     (o_err_cnt)
    );

    typedef struct {
        logic [5:0]  a;
        logic [31:0] d;
        logic [15:0] en;
    } wr_t;

    int   checks = 0;
    int   errors = 0;
    wr_t  exp_wr[$];
    bit   exp_ev[$];
    logic [15:0] m_slot = 16'h0;
    logic [9:0]  m_dly[8];
    int   m_err = 0;
    int   n_wr = 0;
    logic [5:0] last_addr = 6'd0;
    bit   toggle = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle compare against the expected write and pulse streams
    always @(negedge clk) begin
        wr_t e;
        bit  ev;
        if (!rst) begin
            if (o_wren != 16'h0) begin
                n_wr++;
                last_addr = o_wr_addr;
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", 32'(o_wren), 32'h0);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wren", 32'(o_wren), 32'(e.en));
                    chk("wr_addr", 32'(o_wr_addr), 32'(e.a));
                    chk("wr_data", o_wr_data, e.d);
                end
            end
            chk("ok_err_exclusive", 32'(o_frame_ok & o_frame_err), 32'h0);
            if (o_frame_ok || o_frame_err) begin
                if (exp_ev.size() == 0) begin
                    chk("unexpected_pulse", 32'({o_frame_ok, o_frame_err}), 32'h0);
                end else begin
                    ev = exp_ev.pop_front();
                    chk("pulse", 32'({o_frame_ok, o_frame_err}), ev ? 32'h2 : 32'h1);
                    if (!ev && m_err < 255)
                        m_err++;
                end
            end
            chk("err_cnt", 32'(o_err_cnt), 32'(m_err));
        end
    end

    task automatic send(input logic [31:0] w);
        int n = 0;
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        @(posedge clk);
        while (!bus.in_ready && n < 20) begin
            n++;
            @(posedge clk);
        end
        if (n >= 20)
            chk("accept_timeout", 32'(bus.in_ready), 32'h1);
        #1;
        bus.in_valid = 1'b0;
        if (toggle) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input logic [3:0] ty, input logic [2:0] ch,
                         input logic [31:0] base, input bit bad_sum,
                         input int abort_after);
        int n;
        logic [31:0] w;
        logic [31:0] acc = 32'h0;
        logic [3:0]  slot;
        bit good;
        n    = (ty == 4'h1) ? 32 : (ty == 4'h2) ? 47 : 1;
        slot = {ty == 4'h2, ch};
        if (ty != 4'h3)
            m_slot[slot] = 1'b0;
        send({8'hA5, ty, 1'b1, ch, 16'hBEEF});
        for (int i = 0; i < n; i++) begin
            if (abort_after == i)
                return;
            w = (ty == 4'h3) ? base : base + i;
            acc ^= w;
            if (ty != 4'h3)
                exp_wr.push_back('{a: 6'(i), d: w, en: 16'h1 << slot});
            send(w);
        end
        good = !bad_sum && (ty != 4'h3 || base[9:0] <= 10'd1022);
        exp_ev.push_back(good);
        send(acc ^ {31'h0, bad_sum});
        if (good) begin
            if (ty == 4'h3)
                m_dly[ch] = base[9:0];
            else
                m_slot[slot] = 1'b1;
        end
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
        chk("pending_writes", 32'(exp_wr.size()), 32'h0);
        chk("pending_pulses", 32'(exp_ev.size()), 32'h0);
        chk("slot_loaded", 32'(o_slot_loaded), 32'(m_slot));
        for (int c = 0; c < 8; c++)
            chk($sformatf("delay_ca%0d", c), 32'(o_delay_ca[c]), 32'(m_dly[c]));
    endtask

    task automatic check_zero();
        chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
        chk("rst_wren", 32'(o_wren), 32'h0);
        chk("rst_wr_addr", 32'(o_wr_addr), 32'h0);
        chk("rst_wr_data", o_wr_data, 32'h0);
        chk("rst_slot", 32'(o_slot_loaded), 32'h0);
        chk("rst_pulses", 32'({o_frame_ok, o_frame_err}), 32'h0);
        chk("rst_err_cnt", 32'(o_err_cnt), 32'h0);
        chk("rst_delay_any", 32'(|o_delay_ca), 32'h0);
    endtask

    task automatic do_reset();
        #1;
        rst = 1'b1;
        m_slot = 16'h0;
        m_err  = 0;
        for (int c = 0; c < 8; c++)
            m_dly[c] = 10'd0;
        exp_wr.delete();
        exp_ev.delete();
        repeat (2) @(posedge clk);
        #1;
        check_zero();
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'h1);
    endtask

    initial begin
        bus.in_data  = 32'h0;
        bus.in_valid = 1'b0;
        for (int c = 0; c < 8; c++)
            m_dly[c] = 10'd0;
        repeat (3) @(posedge clk);
        #1;
        check_zero();
        rst = 1'b0;
        @(posedge clk);
        #1;

        n_wr = 0;
        frame(4'h1, 3'd3, 32'h1000_0000, 1'b0, -1);
        settle();
        chk("t1_writes", 32'(n_wr), 32'd32);
        chk("t1_last_addr", 32'(last_addr), 32'd31);
        chk("t1_slot", 32'(o_slot_loaded), 32'h0008);

        n_wr = 0;
        frame(4'h2, 3'd7, 32'h2000_0000, 1'b0, -1);
        settle();
        chk("t2_writes", 32'(n_wr), 32'd47);
        chk("t2_last_addr", 32'(last_addr), 32'd46);
        chk("t2_slot", 32'(o_slot_loaded), 32'h8008);

        n_wr = 0;
        frame(4'h3, 3'd5, 32'hFFC0_0000 | 32'd600, 1'b0, -1);
        settle();
        chk("t3_delay5", 32'(o_delay_ca[5]), 32'd600);
        frame(4'h3, 3'd5, 32'd1023, 1'b0, -1);
        settle();
        chk("t3_delay5_kept", 32'(o_delay_ca[5]), 32'd600);
        chk("t3_err_cnt", 32'(o_err_cnt), 32'd1);
        frame(4'h3, 3'd6, 32'd1022, 1'b0, -1);
        settle();
        chk("t3_delay6_max", 32'(o_delay_ca[6]), 32'd1022);
        chk("t3_no_ram_write", 32'(n_wr), 32'd0);

        n_wr = 0;
        frame(4'h1, 3'd0, 32'h4000_0000, 1'b1, -1);
        settle();
        chk("t4_writes", 32'(n_wr), 32'd32);
        chk("t4_slot0", 32'(o_slot_loaded[0]), 32'h0);
        chk("t4_err_cnt", 32'(o_err_cnt), 32'd2);

        for (int i = 0; i < 5; i++)
            send(32'h1234_5600 + 32'(i));
        exp_ev.push_back(1'b0);
        send({8'hA5, 4'h9, 1'b0, 3'd2, 16'h0});
        frame(4'h2, 3'd1, 32'h5000_0000, 1'b0, -1);
        settle();
        chk("t5_slot", 32'(o_slot_loaded), 32'h8208);
        chk("t5_err_cnt", 32'(o_err_cnt), 32'd3);

        n_wr = 0;
        frame(4'h1, 3'd2, 32'h6600_0000, 1'b0, 10);
        @(posedge clk);
        #1;
        chk("t6_partial_writes", 32'(n_wr), 32'd10);
        do_reset();
        n_wr = 0;
        frame(4'h1, 3'd2, 32'h6000_0000, 1'b0, -1);
        settle();
        chk("t6_writes", 32'(n_wr), 32'd32);
        chk("t6_slot", 32'(o_slot_loaded), 32'h0004);
        toggle = 1'b1;
        n_wr = 0;
        frame(4'h1, 3'd2, 32'h6000_0000, 1'b0, -1);
        settle();
        toggle = 1'b0;
        chk("t6_toggle_writes", 32'(n_wr), 32'd32);
        chk("t6_toggle_last", 32'(last_addr), 32'd31);
        chk("t6_toggle_slot", 32'(o_slot_loaded), 32'h0004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
